// File: rtl/cpu_pkg.sv
// Shared opcode and FSM state definitions for the cpu_gen core.
package cpu_pkg;

  // Opcodes live in byte0[7:4] of every instruction.
  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_SET   = 4'd3;
  localparam logic [3:0] OP_LT    = 4'd4;
  localparam logic [3:0] OP_EQ    = 4'd5;
  localparam logic [3:0] OP_BEQ   = 4'd6;
  localparam logic [3:0] OP_BNEQ  = 4'd7;
  localparam logic [3:0] OP_ADD   = 4'd8;
  localparam logic [3:0] OP_SUB   = 4'd9;
  localparam logic [3:0] OP_SHL   = 4'd10;
  localparam logic [3:0] OP_SHR   = 4'd11;
  localparam logic [3:0] OP_AND   = 4'd12;
  localparam logic [3:0] OP_OR    = 4'd13;
  localparam logic [3:0] OP_INV   = 4'd14;
  localparam logic [3:0] OP_XOR   = 4'd15;

  // F0 fetches byte0, F1 fetches byte1 and executes, MEM runs the data transfer.
  typedef enum logic [1:0] {
    ST_F0  = 2'd0,
    ST_F1  = 2'd1,
    ST_MEM = 2'd2
  } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the register-register operations (LT, EQ, ADD..XOR).
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [3:0]    i_op,
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_y
);

  // Shift amounts at or beyond the word width flush the result to zero.
  localparam logic [DW-1:0] SHIFT_LIM = DW'(DW);

  // Select the result for the current opcode; non-ALU opcodes give zero.
  always_comb begin
    o_y = '0;
    case (i_op)
      OP_LT:   o_y = DW'(i_a < i_b);
      OP_EQ:   o_y = DW'(i_a == i_b);
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_SHL:  o_y = (i_b >= SHIFT_LIM) ? '0 : (i_a << i_b);
      OP_SHR:  o_y = (i_b >= SHIFT_LIM) ? '0 : (i_a >> i_b);
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_INV:  o_y = ~i_a;
      OP_XOR:  o_y = i_a ^ i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/cpu_gen.sv
// Small 16-register CPU: 2-byte instructions, R15 is the PC, one memory port
// with a ready handshake. Register file, FSM and PC logic live here.
module cpu_gen
  import cpu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          write,
  output logic          read,
  output logic [AW-1:0] address,
  output logic [DW-1:0] dout,
  input  logic [DW-1:0] din,
  input  logic          ready
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_regs [16];
  logic [3:0]    r_op;
  logic [3:0]    r_dest;
  logic [AW-1:0] r_addr;
  logic          r_write;
  logic [DW-1:0] r_dout;

  logic [3:0]    w_op_nxt;
  logic [3:0]    w_dest_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic          w_write_nxt;
  logic [DW-1:0] w_dout_nxt;
  logic [DW-1:0] w_pc_nxt;
  logic          w_rf_we;
  logic [DW-1:0] w_rf_wdata;

  logic [DW-1:0] w_pc;
  logic [3:0]    w_a1;
  logic [3:0]    w_a2;
  logic [DW-1:0] w_const;
  logic [DW-1:0] w_ra1;
  logic [DW-1:0] w_ra2;
  logic [DW-1:0] w_rdest;
  logic [DW-1:0] w_ea;
  logic [DW-1:0] w_alu_y;

  // Byte1 fields are decoded straight off the bus during F1.
  assign w_pc    = r_regs[15];
  assign w_a1    = din[7:4];
  assign w_a2    = din[3:0];
  assign w_const = DW'(din[7:0]);
  assign w_ra1   = r_regs[w_a1];
  assign w_ra2   = r_regs[w_a2];
  assign w_rdest = r_regs[r_dest];
  assign w_ea    = w_ra1 + DW'(w_a2);

  assign write   = r_write;
  assign read    = ~r_write;
  assign dout    = r_dout;
  assign address = (r_state == ST_MEM) ? r_addr : w_pc[AW-1:0];

  cpu_alu #(.DW(DW)) u_alu (
    .i_op (r_op),
    .i_a  (w_ra1),
    .i_b  (w_ra2),
    .o_y  (w_alu_y)
  );

  // Next-state, PC and register-write decode; nothing moves unless ready=1.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_dest_nxt  = r_dest;
    w_addr_nxt  = r_addr;
    w_write_nxt = r_write;
    w_dout_nxt  = r_dout;
    w_pc_nxt    = w_pc;
    w_rf_we     = 1'b0;
    w_rf_wdata  = '0;
    unique case (r_state)
      ST_F0: begin
        if (ready) begin
          w_op_nxt    = din[7:4];
          w_dest_nxt  = din[3:0];
          w_pc_nxt    = w_pc + DW'(1);
          w_state_nxt = ST_F1;
        end
      end
      ST_F1: begin
        if (ready) begin
          w_pc_nxt    = w_pc + DW'(1);
          w_state_nxt = ST_F0;
          case (r_op)
            OP_NOP: begin
            end
            OP_LOAD: begin
              w_addr_nxt  = w_ea[AW-1:0];
              w_state_nxt = ST_MEM;
            end
            OP_STORE: begin
              w_addr_nxt  = w_ea[AW-1:0];
              w_write_nxt = 1'b1;
              w_dout_nxt  = w_rdest;
              w_state_nxt = ST_MEM;
            end
            OP_SET: begin
              w_rf_we    = 1'b1;
              w_rf_wdata = w_const;
            end
            OP_BEQ: begin
              if (w_rdest == w_const) w_pc_nxt = w_pc + DW'(3);
            end
            OP_BNEQ: begin
              if (w_rdest != w_const) w_pc_nxt = w_pc + DW'(3);
            end
            default: begin
              w_rf_we    = 1'b1;
              w_rf_wdata = w_alu_y;
            end
          endcase
        end
      end
      ST_MEM: begin
        if (ready) begin
          w_write_nxt = 1'b0;
          w_state_nxt = ST_F0;
          if (r_op == OP_LOAD) begin
            w_rf_we    = 1'b1;
            w_rf_wdata = din;
          end
        end
      end
      default: w_state_nxt = ST_F0;
    endcase
  end

  // FSM state and bus-side registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_F0;
      r_op    <= '0;
      r_dest  <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_dout  <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_dest  <= w_dest_nxt;
      r_addr  <= w_addr_nxt;
      r_write <= w_write_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  // Register file; a dest write to R15 lands after the PC update and so wins (jump).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: this is a flop array, not a RAM macro, so it can take the async clear.
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      r_regs[15] <= w_pc_nxt;
      if (w_rf_we) r_regs[r_dest] <= w_rf_wdata;
    end
  end

endmodule

// File: tb/tb_cpu_gen.sv
// Directed bench: an 8-bit core runs the main program, a 16-bit core runs the
// shift/width program. Each core sees a simple memory: fixed program bytes
// plus a written-data overlay.
module tb_cpu_gen;

  logic        clk = 1'b0;
  logic        rst8, rst16, ready8, ready16;
  logic        write8, read8, write16, read16;
  logic [7:0]  address8, address16;
  logic [7:0]  dout8, din8;
  logic [15:0] dout16, din16;

  logic [7:0]  dmem8  [256];
  bit          dvalid8 [256];
  logic [15:0] dmem16 [256];
  bit          dvalid16 [256];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_gen #(.DW(8), .AW(8)) u_dut8 (
    .clk(clk), .rst(rst8), .write(write8), .read(read8),
    .address(address8), .dout(dout8), .din(din8), .ready(ready8)
  );

  cpu_gen #(.DW(16), .AW(8)) u_dut16 (
    .clk(clk), .rst(rst16), .write(write16), .read(read16),
    .address(address16), .dout(dout16), .din(din16), .ready(ready16)
  );

  // Main 8-bit program, one instruction per line.
  function automatic logic [7:0] prog8(input logic [7:0] a);
    logic [7:0] r;
    case (a)
      8'd0:  r = 8'h31; 8'd1:  r = 8'h05;  // SET R1,0x05
      8'd2:  r = 8'h32; 8'd3:  r = 8'hFB;  // SET R2,0xFB
      8'd4:  r = 8'h83; 8'd5:  r = 8'h12;  // ADD R3,R1,R2 -> 0x00
      8'd6:  r = 8'h23; 8'd7:  r = 8'h20;  // STORE R3,[R2+0]
      8'd8:  r = 8'h31; 8'd9:  r = 8'h40;  // SET R1,0x40
      8'd10: r = 8'h21; 8'd11: r = 8'h12;  // STORE R1,[R1+2]
      8'd12: r = 8'h14; 8'd13: r = 8'h12;  // LOAD R4,[R1+2]
      8'd14: r = 8'h24; 8'd15: r = 8'h15;  // STORE R4,[R1+5]
      8'd16: r = 8'h35; 8'd17: r = 8'h07;  // SET R5,7
      8'd18: r = 8'h65; 8'd19: r = 8'h07;  // BEQ R5,7 (taken)
      8'd20: r = 8'h36; 8'd21: r = 8'hAA;  // SET R6,0xAA (skipped)
      8'd22: r = 8'h75; 8'd23: r = 8'h07;  // BNEQ R5,7 (not taken)
      8'd24: r = 8'h97; 8'd25: r = 8'h12;  // SUB R7,R1,R2 -> 0x45
      8'd26: r = 8'hF8; 8'd27: r = 8'h12;  // XOR R8,R1,R2 -> 0xBB
      8'd28: r = 8'h49; 8'd29: r = 8'h12;  // LT  R9,R1,R2 -> 1
      8'd30: r = 8'hEA; 8'd31: r = 8'h10;  // INV R10,R1 -> 0xBF
      8'd32: r = 8'hCB; 8'd33: r = 8'h27;  // AND R11,R2,R7 -> 0x41
      8'd34: r = 8'h5C; 8'd35: r = 8'h41;  // EQ  R12,R4,R1 -> 1
      8'd36: r = 8'hDD; 8'd37: r = 8'h19;  // OR  R13,R1,R9 -> 0x41
      8'd38: r = 8'hBE; 8'd39: r = 8'h19;  // SHR R14,R1,R9 -> 0x20
      8'd40: r = 8'h27; 8'd41: r = 8'h17;  // STORE R7,[R1+7]
      8'd42: r = 8'h28; 8'd43: r = 8'h18;  // STORE R8,[R1+8]
      8'd44: r = 8'h29; 8'd45: r = 8'h19;  // STORE R9,[R1+9]
      8'd46: r = 8'h2A; 8'd47: r = 8'h1A;  // STORE R10,[R1+10]
      8'd48: r = 8'h2B; 8'd49: r = 8'h1B;  // STORE R11,[R1+11]
      8'd50: r = 8'h2C; 8'd51: r = 8'h1C;  // STORE R12,[R1+12]
      8'd52: r = 8'h2D; 8'd53: r = 8'h1D;  // STORE R13,[R1+13]
      8'd54: r = 8'h2E; 8'd55: r = 8'h1E;  // STORE R14,[R1+14]
      8'd56: r = 8'h3F; 8'd57: r = 8'hFE;  // SET R15,0xFE (jump)
      default: r = 8'h00;                  // NOP
    endcase
    return r;
  endfunction

  // 16-bit shift/width program; the bus upper byte carries junk that must be ignored.
  function automatic logic [7:0] prog16(input logic [7:0] a);
    logic [7:0] r;
    case (a)
      8'd0:  r = 8'h31; 8'd1:  r = 8'h80;  // SET R1,0x80
      8'd2:  r = 8'h32; 8'd3:  r = 8'h08;  // SET R2,8
      8'd4:  r = 8'hA3; 8'd5:  r = 8'h12;  // SHL R3,R1,R2 -> 0x8000
      8'd6:  r = 8'h34; 8'd7:  r = 8'h0F;  // SET R4,15
      8'd8:  r = 8'hB5; 8'd9:  r = 8'h34;  // SHR R5,R3,R4 -> 0x0001
      8'd10: r = 8'h36; 8'd11: r = 8'h10;  // SET R6,16
      8'd12: r = 8'hA7; 8'd13: r = 8'h36;  // SHL R7,R3,R6 -> 0
      8'd14: r = 8'h38; 8'd15: r = 8'hFF;  // SET R8,0xFF
      8'd16: r = 8'hA9; 8'd17: r = 8'h82;  // SHL R9,R8,R2 -> 0xFF00
      8'd18: r = 8'h23; 8'd19: r = 8'h13;  // STORE R3,[R1+3]
      8'd20: r = 8'h25; 8'd21: r = 8'h15;  // STORE R5,[R1+5]
      8'd22: r = 8'h27; 8'd23: r = 8'h17;  // STORE R7,[R1+7]
      8'd24: r = 8'h29; 8'd25: r = 8'h19;  // STORE R9,[R1+9]
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign din8  = dvalid8[address8]   ? dmem8[address8]   : prog8(address8);
  assign din16 = dvalid16[address16] ? dmem16[address16] : {8'hA5, prog16(address16)};

  // Memory write port: a store lands on the cycle it completes (write & ready).
  always @(posedge clk) begin
    if (rst8 && write8 && ready8) begin
      dmem8[address8]   <= dout8;
      dvalid8[address8] <= 1'b1;
    end
    if (rst16 && write16 && ready16) begin
      dmem16[address16]   <= dout16;
      dvalid16[address16] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run until the selected core raises write (bounded), then check the transfer.
  task automatic expect_store(input string tag, input bit wide,
                              input logic [7:0] exp_addr, input logic [15:0] exp_data);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      seen = wide ? (write16 === 1'b1) : (write8 === 1'b1);
    end
    check({tag, "_seen"}, 16'(seen), 16'd1);
    if (seen) begin
      check({tag, "_addr"}, wide ? 16'(address16) : 16'(address8), 16'(exp_addr));
      check({tag, "_data"}, wide ? dout16 : 16'(dout8), exp_data);
    end
  endtask

  initial begin
    rst8 = 1'b1; rst16 = 1'b1; ready8 = 1'b1; ready16 = 1'b1;
    #1 rst8 = 1'b0; rst16 = 1'b0;
    #1;
    check("rst_write", 16'(write8), 16'd0);
    check("rst_read",  16'(read8),  16'd1);
    check("rst_addr",  16'(address8), 16'h00);
    check("rst_dout",  16'(dout8),  16'h00);
    tick(); tick();
    check("rst_hold_addr", 16'(address8), 16'h00);

    // First fetch from 0, then 1.
    rst8 = 1'b1;
    tick();
    check("fetch1_addr",  16'(address8), 16'h01);
    check("fetch1_write", 16'(write8), 16'd0);

    // SET/SET/ADD then STORE R3 -> 0x00 at 0xFB.
    repeat (7) tick();
    check("st_r3_write", 16'(write8), 16'd1);
    check("st_r3_read",  16'(read8), 16'd0);
    check("st_r3_addr",  16'(address8), 16'hFB);
    check("st_r3_data",  16'(dout8), 16'h00);
    tick();
    check("st_r3_done_write", 16'(write8), 16'd0);
    check("st_r3_done_addr",  16'(address8), 16'h08);

    // STORE R1,[R1+2] with two stall cycles in MEM.
    repeat (4) tick();
    check("st_r1_write", 16'(write8), 16'd1);
    check("st_r1_addr",  16'(address8), 16'h42);
    check("st_r1_data",  16'(dout8), 16'h40);
    ready8 = 1'b0;
    tick();
    check("stall1_write", 16'(write8), 16'd1);
    check("stall1_addr",  16'(address8), 16'h42);
    tick();
    check("stall2_write", 16'(write8), 16'd1);
    check("stall2_data",  16'(dout8), 16'h40);
    ready8 = 1'b1;
    tick();
    check("st_r1_done_write", 16'(write8), 16'd0);
    check("st_r1_done_addr",  16'(address8), 16'h0C);

    // Stall in F0: PC and address hold.
    ready8 = 1'b0;
    tick(); tick();
    check("f0_stall_addr",  16'(address8), 16'h0C);
    check("f0_stall_write", 16'(write8), 16'd0);
    ready8 = 1'b1;

    // LOAD R4,[R1+2] then STORE R4 to observe it.
    tick();
    check("ld_f1_addr", 16'(address8), 16'h0D);
    tick();
    check("ld_mem_addr",  16'(address8), 16'h42);
    check("ld_mem_write", 16'(write8), 16'd0);
    tick();
    check("ld_done_addr", 16'(address8), 16'h0E);
    expect_store("st_r4", 1'b0, 8'h45, 16'h0040);

    // SET R5,7; BEQ taken skips to 22; BNEQ not taken falls through to 24.
    repeat (5) tick();
    check("beq_taken_addr", 16'(address8), 16'h16);
    tick(); tick();
    check("bneq_fall_addr", 16'(address8), 16'h18);

    // ALU results observed through stores.
    expect_store("sub",  1'b0, 8'h47, 16'h0045);
    expect_store("xor",  1'b0, 8'h48, 16'h00BB);
    expect_store("lt",   1'b0, 8'h49, 16'h0001);
    expect_store("inv",  1'b0, 8'h4A, 16'h00BF);
    expect_store("and",  1'b0, 8'h4B, 16'h0041);
    expect_store("eq",   1'b0, 8'h4C, 16'h0001);
    expect_store("or",   1'b0, 8'h4D, 16'h0041);
    expect_store("shr",  1'b0, 8'h4E, 16'h0020);

    // SET R15,0xFE: jump, then PC wraps through 0xFF to 0x00.
    tick(); tick();
    tick();
    check("jump_addr", 16'(address8), 16'hFE);
    tick();
    check("wrap_ff_addr", 16'(address8), 16'hFF);
    tick();
    check("wrap_00_addr", 16'(address8), 16'h00);

    // Program reruns; reset lands in the middle of the STORE.
    expect_store("rerun_r3", 1'b0, 8'hFB, 16'h0000);
    ready8 = 1'b0;
    rst8 = 1'b0;
    #1;
    check("abort_write", 16'(write8), 16'd0);
    check("abort_read",  16'(read8), 16'd1);
    check("abort_addr",  16'(address8), 16'h00);
    tick();
    check("abort_hold_addr", 16'(address8), 16'h00);
    ready8 = 1'b1;
    rst8 = 1'b1;
    tick();
    check("refetch_addr", 16'(address8), 16'h01);

    // 16-bit core: shift width behaviour and byte0/byte1 decode from din[7:0].
    check("w16_rst_addr", 16'(address16), 16'h00);
    rst16 = 1'b1;
    tick();
    check("w16_fetch_addr", 16'(address16), 16'h01);
    expect_store("w16_shl8",   1'b1, 8'h83, 16'h8000);
    expect_store("w16_shr15",  1'b1, 8'h85, 16'h0001);
    expect_store("w16_shl16",  1'b1, 8'h87, 16'h0000);
    expect_store("w16_shl_ff", 1'b1, 8'h89, 16'hFF00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
